cmm_apb2hst_mc: RTL and testbench
=================================

Name: cmm_apb2hst_mc

Overview:
- Multi-channel APB4 slave to host-interface bridge for VMM RALF style register hosts.
- Decodes each APB transfer to one of C_NCH host channels and issues a one-cycle request.
- Waits for the selected channel's acknowledge with a programmable timeout, inserting APB wait states.
- Returns host read data and error status, or PSLVERR on decode, privilege or timeout fault.

Parameters:
- C_AW, 32: APB/host address width.
- C_NCH, 4: number of host channels (1..16).
- C_CH_AW, 12: address bits per channel window. Channel index is paddr[C_CH_AW +: CW], where CW = max(1, clog2(C_NCH)).
- C_TMO, 16: cycles to wait for hst_ack before timeout (2..255).
- C_PRIV_ONLY, 0: when 1, transfers with pprot[0]=0 are rejected with PSLVERR.

Ports:
- apb_pclk  in  1  clock
- apb_presetn  in  1  reset; asynchronous, active-low
- apb_psel  in  1  APB select
- apb_penable  in  1  APB enable
- apb_pwrite  in  1  1 = write
- apb_pprot  in  3  APB4 protection
- apb_paddr  in  C_AW  address
- apb_pwdata  in  32  write data
- apb_pwstrb  in  4  write strobes
- apb_pready  out  1  transfer complete
- apb_prdata  out  32  read data
- apb_pslverr  out  1  transfer error
- hst_req  out  C_NCH  one-hot, one-cycle request per channel
- hst_addr  out  C_AW  latched address (full paddr)
- hst_wen  out  1  latched pwrite
- hst_sel  out  4  latched byte select: pwstrb on write, 4'hF on read
- hst_wdat  out  32  latched write data
- hst_ack  in  C_NCH  per-channel acknowledge
- hst_err  in  C_NCH  per-channel error, qualified by hst_ack
- hst_rdat  in  32*C_NCH  per-channel read data, channel k at [32k+:32], qualified by hst_ack

Behaviour:
- Reset (async, apb_presetn=0) values: state IDLE; apb_pready=0, apb_prdata=0, apb_pslverr=0; hst_req=0, hst_addr=0, hst_wen=0, hst_sel=0, hst_wdat=0; timeout counter 0. Reset mid-transfer drops any in-flight request; a later hst_ack is ignored.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on psel=1 and penable=0, latch addr, wen, sel, wdat and channel index.
  - Fault if any of: paddr >= C_NCH << C_CH_AW (decode); or C_PRIV_ONLY=1 and pprot[0]=0 (privilege).
  - Fault → RESP with pslverr=1, prdata=0, no hst_req.
  - Otherwise → REQ.
- REQ: hst_req[ch]=1 for exactly this cycle; counter loads 1. Go to WAIT. hst_ack[ch] sampled in this cycle is valid and behaves as in WAIT.
- WAIT, evaluated in REQ and WAIT cycles:
  - hst_ack[ch]=1 → capture hst_rdat[ch] into prdata (reads only; writes give prdata=0) and hst_err[ch] into pslverr; go to RESP.
  - Else if counter == C_TMO → pslverr=1, prdata=32'hDEAD_0000 | ch; go to RESP.
  - Else counter++.
- Acks on channels other than ch, and any ack outside REQ/WAIT, are ignored. Hosts must not ack after timeout.
- RESP: apb_pready=1 for one cycle, with prdata/pslverr valid. pready, pslverr and prdata are all registered outputs; pslverr and prdata hold their values from entry into RESP through the pready cycle and clear with pready on leaving RESP. Next state is IDLE. Back-to-back setup is accepted in the following IDLE cycle.
- Latency: setup in cycle T0, hst_req in T1. Ack in T1 gives pready in T3 (entry into RESP is registered one cycle after the ack is sampled). Minimum transfer is setup plus 3 access cycles.
- Timeout transfer length: setup + C_TMO + 2 access cycles.
- Abort: psel=0 while in REQ or WAIT (master violation) → IDLE; no pready; pending ack ignored.
- Byte strobes are not interpreted by the bridge; they are forwarded via hst_sel.
- pwstrb on reads is ignored (hst_sel forced to 4'hF).

Test Plan:
- Write ch2 addr 0x2010, wdata 0xA5A5_5A5A, pwstrb 4'b0011; host ack in the cycle after hst_req → hst_req=4'b0100 for 1 cycle, hst_sel=4'b0011, hst_wen=1, pready 2 cycles after ack, pslverr=0.
- Read ch1 addr 0x1004; hst_rdat[1]=0x1234_5678, ack in the same cycle as hst_req → prdata=0x1234_5678, pslverr=0, pready 2 cycles after hst_req.
- Read ch0, never ack, C_TMO=16 → pready after 18 access cycles, pslverr=1, prdata=0xDEAD_0000; subsequent stray hst_ack[0] ignored.
- Read paddr 0x4000 (C_NCH=4) → no hst_req, pready 2 cycles after setup, pslverr=1, prdata=0. Repeat with C_PRIV_ONLY=1 and pprot=3'b000 on a valid address → same response.
- Write ch3 with hst_err[3]=1 on ack → pslverr=1; back-to-back read ch3 starting the cycle after pready completes normally.
- Assert reset in WAIT, then ack after release → all outputs 0, no pready; next transfer is correct.

Source files
------------

// File: rtl/cmm_apb2hst_mc.sv
// APB4 slave to multi-channel register host bridge.
// Each APB transfer is decoded to one host channel, a single-cycle request is
// issued on that channel, and the bridge holds the APB access in wait states
// until the channel acknowledges or the timeout expires.
//
// state | meaning
// IDLE  | waiting for an APB setup phase; latches the transfer
// REQ   | hst_req pulsed this cycle; ack already accepted here
// WAIT  | waiting for ack on the selected channel, counting towards timeout
// RESP  | response captured; pready raised on the second RESP cycle
module cmm_apb2hst_mc #(
    parameter int C_AW        = 32,
    parameter int C_NCH       = 4,
    parameter int C_CH_AW     = 12,
    parameter int C_TMO       = 16,
    parameter int C_PRIV_ONLY = 0
) (
    input  logic                  apb_pclk,
    input  logic                  apb_presetn,
    input  logic                  apb_psel,
    input  logic                  apb_penable,
    input  logic                  apb_pwrite,
    input  logic [2:0]            apb_pprot,
    input  logic [C_AW-1:0]       apb_paddr,
    input  logic [31:0]           apb_pwdata,
    input  logic [3:0]            apb_pwstrb,
    output logic                  apb_pready,
    output logic [31:0]           apb_prdata,
    output logic                  apb_pslverr,
    output logic [C_NCH-1:0]      hst_req,
    output logic [C_AW-1:0]       hst_addr,
    output logic                  hst_wen,
    output logic [3:0]            hst_sel,
    output logic [31:0]           hst_wdat,
    input  logic [C_NCH-1:0]      hst_ack,
    input  logic [C_NCH-1:0]      hst_err,
    input  logic [32*C_NCH-1:0]   hst_rdat
);

    localparam int CW = (C_NCH > 1) ? $clog2(C_NCH) : 1;
    // One bit wider than the address so the window limit never overflows.
    localparam logic [C_AW:0] LIMIT = (C_AW+1)'(C_NCH) << C_CH_AW;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [7:0]          cnt, cnt_nxt;
    logic [CW-1:0]       ch, ch_nxt;
    logic [C_NCH-1:0]    req_nxt;
    logic [C_AW-1:0]     addr_nxt;
    logic                wen_nxt;
    logic [3:0]          sel_nxt;
    logic [31:0]         wdat_nxt;
    logic                pready_nxt;
    logic [31:0]         prdata_nxt;
    logic                pslverr_nxt;

    logic                setup;
    logic                fault;
    logic [CW-1:0]       ch_in;
    logic                ack_hit;
    logic                err_hit;
    logic [31:0]         rdat_sel;
    logic                tmo_hit;
    logic                unused_prot;

    assign setup       = apb_psel && !apb_penable;
    assign ch_in       = apb_paddr[C_CH_AW +: CW];
    assign fault       = ({1'b0, apb_paddr} >= LIMIT) ||
                         ((C_PRIV_ONLY != 0) && !apb_pprot[0]);
    assign ack_hit     = hst_ack[ch];
    assign err_hit     = hst_err[ch];
    assign rdat_sel    = hst_rdat[32*ch +: 32];
    assign tmo_hit     = (cnt == 8'(C_TMO));
    assign unused_prot = ^apb_pprot[2:1];

    // State and all registered outputs; async reset drops any in-flight transfer.
    always_ff @(posedge apb_pclk or negedge apb_presetn) begin
        if (!apb_presetn) begin
            state       <= IDLE;
            cnt         <= '0;
            ch          <= '0;
            hst_req     <= '0;
            hst_addr    <= '0;
            hst_wen     <= 1'b0;
            hst_sel     <= '0;
            hst_wdat    <= '0;
            apb_pready  <= 1'b0;
            apb_prdata  <= '0;
            apb_pslverr <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ch          <= ch_nxt;
            hst_req     <= req_nxt;
            hst_addr    <= addr_nxt;
            hst_wen     <= wen_nxt;
            hst_sel     <= sel_nxt;
            hst_wdat    <= wdat_nxt;
            apb_pready  <= pready_nxt;
            apb_prdata  <= prdata_nxt;
            apb_pslverr <= pslverr_nxt;
        end
    end

    // Next-state decision; a dropped psel mid-access returns to IDLE silently.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (setup) state_nxt = fault ? RESP : REQ;
            REQ, WAIT: begin
                if (!apb_psel)               state_nxt = IDLE;
                else if (ack_hit || tmo_hit) state_nxt = RESP;
                else                         state_nxt = WAIT;
            end
            RESP: if (apb_pready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, latched transfer fields and timer.
    always_comb begin
        cnt_nxt     = cnt;
        ch_nxt      = ch;
        req_nxt     = '0;
        addr_nxt    = hst_addr;
        wen_nxt     = hst_wen;
        sel_nxt     = hst_sel;
        wdat_nxt    = hst_wdat;
        pready_nxt  = 1'b0;
        prdata_nxt  = apb_prdata;
        pslverr_nxt = apb_pslverr;
        case (state)
            IDLE: begin
                prdata_nxt  = '0;
                pslverr_nxt = 1'b0;
                if (setup) begin
                    ch_nxt   = ch_in;
                    addr_nxt = apb_paddr;
                    wen_nxt  = apb_pwrite;
                    sel_nxt  = apb_pwrite ? apb_pwstrb : 4'hF;
                    wdat_nxt = apb_pwdata;
                    if (fault) begin
                        pslverr_nxt = 1'b1;
                    end else begin
                        req_nxt = C_NCH'(1) << ch_in;
                        cnt_nxt = 8'd1;
                    end
                end
            end
            REQ, WAIT: begin
                if (apb_psel) begin
                    if (ack_hit) begin
                        prdata_nxt  = hst_wen ? 32'h0 : rdat_sel;
                        pslverr_nxt = err_hit;
                    end else if (tmo_hit) begin
                        prdata_nxt  = 32'hDEAD_0000 | {{(32-CW){1'b0}}, ch};
                        pslverr_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            RESP: begin
                if (!apb_pready) begin
                    pready_nxt = 1'b1;
                end else begin
                    prdata_nxt  = '0;
                    pslverr_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cmm_apb2hst_mc.sv
// Scoreboard bench for cmm_apb2hst_mc: a driver issues APB transfers and plays
// the host side, pushing expected host requests and APB responses into queues;
// a negedge monitor pops and compares whenever the DUTs present an output.
// A second instance with privileged-only access shares the same bus.
module tb_cmm_apb2hst_mc;
    localparam int AW   = 32;
    localparam int NCH  = 4;
    localparam int CHAW = 12;
    localparam int TMO  = 16;
    localparam logic [31:0] WIN_END = 32'(NCH) << CHAW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]    pprot = 3'b000;
    logic [31:0]   paddr = '0, pwdata = '0;
    logic [3:0]    pwstrb = '0;
    logic [3:0]    hst_ack = '0, hst_err = '0;
    logic [127:0]  hst_rdat = '0;

    logic          pready, pslverr, wen;
    logic [31:0]   prdata, addr, wdat;
    logic [3:0]    req, sel;
    logic          p_pready, p_pslverr, p_wen;
    logic [31:0]   p_prdata, p_addr, p_wdat;
    logic [3:0]    p_req, p_sel;

    always #5 clk = ~clk;

    cmm_apb2hst_mc #(.C_AW(AW), .C_NCH(NCH), .C_CH_AW(CHAW), .C_TMO(TMO), .C_PRIV_ONLY(0)) u_dut (
        .apb_pclk(clk), .apb_presetn(rstn), .apb_psel(psel), .apb_penable(penable),
        .apb_pwrite(pwrite), .apb_pprot(pprot), .apb_paddr(paddr), .apb_pwdata(pwdata),
        .apb_pwstrb(pwstrb), .apb_pready(pready), .apb_prdata(prdata), .apb_pslverr(pslverr),
        .hst_req(req), .hst_addr(addr), .hst_wen(wen), .hst_sel(sel), .hst_wdat(wdat),
        .hst_ack(hst_ack), .hst_err(hst_err), .hst_rdat(hst_rdat));

    cmm_apb2hst_mc #(.C_AW(AW), .C_NCH(NCH), .C_CH_AW(CHAW), .C_TMO(TMO), .C_PRIV_ONLY(1)) u_priv (
        .apb_pclk(clk), .apb_presetn(rstn), .apb_psel(psel), .apb_penable(penable),
        .apb_pwrite(pwrite), .apb_pprot(pprot), .apb_paddr(paddr), .apb_pwdata(pwdata),
        .apb_pwstrb(pwstrb), .apb_pready(p_pready), .apb_prdata(p_prdata), .apb_pslverr(p_pslverr),
        .hst_req(p_req), .hst_addr(p_addr), .hst_wen(p_wen), .hst_sel(p_sel), .hst_wdat(p_wdat),
        .hst_ack(hst_ack), .hst_err(hst_err), .hst_rdat(hst_rdat));

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } resp_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  sel;
        logic [31:0] wdat;
    } req_t;

    resp_t rq_main[$];
    resp_t rq_priv[$];
    req_t  rq_req[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    setup_cyc = 0;
    req_t  me;
    resp_t mr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every host request and every pready against the queues.
    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            if (psel && !penable) setup_cyc = cyc;
            if (req != 4'h0) begin
                if (rq_req.size() == 0) begin
                    chk("unexpected hst_req", {60'h0, req}, 64'h0);
                end else begin
                    me = rq_req.pop_front();
                    chk("hst_req", {60'h0, req}, {60'h0, me.req});
                    chk("hst_addr", {32'h0, addr}, {32'h0, me.addr});
                    chk("hst_wen", {63'h0, wen}, {63'h0, me.wen});
                    chk("hst_sel", {60'h0, sel}, {60'h0, me.sel});
                    chk("hst_wdat", {32'h0, wdat}, {32'h0, me.wdat});
                end
            end
            if (pready) begin
                if (rq_main.size() == 0) begin
                    chk("unexpected pready", {63'h0, pready}, 64'h0);
                end else begin
                    mr = rq_main.pop_front();
                    chk("prdata", {32'h0, prdata}, {32'h0, mr.data});
                    chk("pslverr", {63'h0, pslverr}, {63'h0, mr.err});
                    chk("pready latency", 64'(cyc - setup_cyc), 64'(mr.lat));
                end
            end
            if (p_pready) begin
                if (rq_priv.size() == 0) begin
                    chk("unexpected priv pready", {63'h0, p_pready}, 64'h0);
                end else begin
                    mr = rq_priv.pop_front();
                    chk("priv prdata", {32'h0, p_prdata}, {32'h0, mr.data});
                    chk("priv pslverr", {63'h0, p_pslverr}, {63'h0, mr.err});
                    chk("priv latency", 64'(cyc - setup_cyc), 64'(mr.lat));
                end
            end
        end
    end

    task automatic idle(input int n, input logic [3:0] ack);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0; hst_ack = ack;
        end
        @(posedge clk); #1;
        hst_ack = 4'h0;
    endtask

    // One APB transfer. ack_at = access cycle of the host ack (0 or > TMO: none).
    // rst_at > 0 pulses reset in that access cycle instead of completing.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] strb, input logic [2:0] prot, input int ack_at,
                        input logic [3:0] err, input logic [127:0] rdat, input int rst_at);
        int     c;
        logic   dec;
        logic   pf;
        logic   acks;
        resp_t  em;
        resp_t  ep;
        req_t   er;
        int     i;
        c    = int'((a >> CHAW) & 32'h3);
        dec  = (a >= WIN_END);
        pf   = !prot[0];
        acks = (ack_at >= 1) && (ack_at <= TMO);
        if (dec) begin
            em = '{data: 32'h0, err: 1'b1, lat: 2};
        end else if (acks) begin
            em = '{data: wr ? 32'h0 : rdat[32*c +: 32], err: err[c], lat: ack_at + 2};
        end else begin
            em = '{data: 32'hDEAD_0000 | 32'(c), err: 1'b1, lat: TMO + 2};
        end
        ep = (pf && !dec) ? '{data: 32'h0, err: 1'b1, lat: 2} : em;
        if (!dec) begin
            er = '{req: 4'(1 << c), addr: a, wen: wr, sel: wr ? strb : 4'hF, wdat: wd};
            rq_req.push_back(er);
        end
        if (rst_at == 0) begin
            rq_main.push_back(em);
            rq_priv.push_back(ep);
        end
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        pwstrb = strb; pprot = prot; hst_err = err; hst_rdat = rdat; hst_ack = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        for (i = 1; i <= 100; i++) begin
            if (i == rst_at) begin
                rstn = 1'b0; psel = 1'b0; penable = 1'b0; hst_ack = 4'h0;
                @(negedge clk);
                chk("reset apb outs", {30'h0, pready, pslverr, prdata}, 64'h0);
                chk("reset host outs", {23'h0, req, wen, sel, wdat}, 64'h0);
                chk("reset host addr", {32'h0, addr}, 64'h0);
                @(posedge clk); #1;
                rstn = 1'b1; hst_ack = 4'(1 << c);
                @(posedge clk); #1;
                hst_ack = 4'h0;
                return;
            end
            hst_ack = (i == ack_at) ? 4'(1 << c) : 4'h0;
            @(negedge clk);
            if (pready) break;
            @(posedge clk); #1;
        end
        if (i > 100) begin
            total++;
            bad++;
            $display("FAIL pready wait: no pready within 100 cycles, addr %0h", a);
        end
    endtask

    initial begin
        logic [127:0] rd;
        logic         wr;
        logic [31:0]  a;
        int           chs;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset apb outs", {30'h0, pready, pslverr, prdata}, 64'h0);
        chk("reset host outs", {23'h0, req, wen, sel, wdat}, 64'h0);
        chk("reset host addr", {32'h0, addr}, 64'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2, 4'h0);

        // Write ch2, host acks the cycle after the request.
        xfer(1'b1, 32'h2010, 32'hA5A5_5A5A, 4'b0011, 3'b001, 2, 4'h0, '0, 0);
        idle(1, 4'h0);
        // Read ch1, ack together with the request.
        rd = '0; rd[63:32] = 32'h1234_5678;
        xfer(1'b0, 32'h1004, 32'h0, 4'h0, 3'b001, 1, 4'h0, rd, 0);
        idle(1, 4'h0);
        // Read ch0 never acked, then a stray ack while idle.
        xfer(1'b0, 32'h0000, 32'h0, 4'hF, 3'b001, 0, 4'h0, {4{32'h5555_AAAA}}, 0);
        idle(3, 4'h1);
        // Decode fault (also carries a stray ack on the decoded channel bits).
        xfer(1'b0, 32'h4000, 32'h0, 4'h0, 3'b001, 1, 4'h0, '1, 0);
        idle(1, 4'h0);
        // Unprivileged access: plain instance completes, privileged one faults.
        rd = '0; rd[127:96] = 32'hCAFE_0003;
        xfer(1'b0, 32'h3008, 32'h0, 4'h0, 3'b000, 3, 4'h0, rd, 0);
        idle(1, 4'h0);
        // Host error on write ch3, then back-to-back read ch3.
        xfer(1'b1, 32'h3100, 32'h0BAD_F00D, 4'b1100, 3'b011, 1, 4'h8, '0, 0);
        rd = '0; rd[127:96] = 32'h0033_3333;
        xfer(1'b0, 32'h3104, 32'h0, 4'h3, 3'b001, 2, 4'h0, rd, 0);
        idle(1, 4'h0);
        // Reset while waiting, ack arrives after release and must be ignored.
        xfer(1'b0, 32'h2000, 32'h0, 4'h0, 3'b001, 0, 4'h0, '1, 3);
        idle(3, 4'h0);
        rd = '0; rd[63:32] = 32'h7777_1111;
        xfer(1'b0, 32'h1FFC, 32'h0, 4'h0, 3'b101, 4, 4'h0, rd, 0);
        idle(1, 4'h0);

        for (int n = 0; n < 60; n++) begin
            wr  = 1'($urandom_range(0, 1));
            chs = $urandom_range(0, 4);
            a   = (32'(chs) << CHAW) | ($urandom & 32'h0FFC);
            if ($urandom_range(0, 9) == 0) a = a | ($urandom & 32'hFFFF_0000);
            rd  = {$urandom, $urandom, $urandom, $urandom};
            xfer(wr, a, $urandom, 4'($urandom), 3'($urandom), $urandom_range(1, TMO + 3),
                 4'($urandom), rd, 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 4'h0);
        end
        idle(4, 4'h0);

        chk("req queue drained", 64'(rq_req.size()), 64'h0);
        chk("main resp queue drained", 64'(rq_main.size()), 64'h0);
        chk("priv resp queue drained", 64'(rq_priv.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
